// File: rtl/regfile_z_nr1w_param_pkg.sv
// Shared types and helpers for the zero-entry register file and its clear engine.
package regfile_pkg;

  typedef enum logic {RF_IDLE, RF_CLEAR} rf_state_t;

  // Address width for a given entry count, never below one bit.
  function automatic int unsigned calc_aw(input int unsigned num_regs);
    return (num_regs <= 2) ? 1 : $clog2(num_regs);
  endfunction

endpackage

// File: rtl/regfile_z_nr1w_param_if.sv
// Bundle of write, read, clear and scoreboard signals between the core and the register file.
interface regfile_z_nr1w_param_if #(
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned N_RD     = 2
);
  import regfile_pkg::*;

  localparam int unsigned AW = calc_aw(NUM_REGS);

  logic                     wen;
  logic [AW-1:0]            waddr;
  logic [DATA_W-1:0]        wdata;
  logic [N_RD*AW-1:0]       raddr;
  logic [N_RD*DATA_W-1:0]   rdata;
  logic                     clear_req;
  logic                     busy;
  logic                     alloc_en;
  logic [AW-1:0]            alloc_addr;
  logic [NUM_REGS-1:0]      pending;

  modport master (
    output wen, waddr, wdata, raddr, clear_req, alloc_en, alloc_addr,
    input  rdata, busy, pending
  );

  modport slave (
    input  wen, waddr, wdata, raddr, clear_req, alloc_en, alloc_addr,
    output rdata, busy, pending
  );

endinterface

// File: rtl/regfile_z_nr1w_param_clear_fsm.sv
// Sequential clear engine: walks entries 1..NUM_REGS-1 writing zero, one entry per cycle.
module regfile_clear_fsm
  import regfile_pkg::*;
#(
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned AW       = calc_aw(NUM_REGS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear_req_i,
  output logic          busy_o,
  output logic          clr_wen_o,
  output logic [AW-1:0] clr_addr_o
);

  localparam logic [AW-1:0] LastIdx  = AW'(NUM_REGS - 1);
  localparam logic [AW-1:0] FirstIdx = AW'(1);

  rf_state_t     state_q, state_d;
  logic [AW-1:0] clr_idx_q, clr_idx_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= RF_CLEAR;
      clr_idx_q <= FirstIdx;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
    end
  end

  // Sweep stops on the last index rather than wrapping back onto entry 0.
  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    unique case (state_q)
      RF_IDLE: begin
        if (clear_req_i) begin
          state_d   = RF_CLEAR;
          clr_idx_d = FirstIdx;
        end
      end
      RF_CLEAR: begin
        if (clr_idx_q == LastIdx) begin
          state_d = RF_IDLE;
        end else begin
          clr_idx_d = clr_idx_q + FirstIdx;
        end
      end
    endcase
  end

  always_comb begin
    busy_o     = (state_q == RF_CLEAR);
    clr_wen_o  = busy_o;
    clr_addr_o = clr_idx_q;
  end

endmodule

// File: rtl/regfile_z_nr1w_param.sv
// NUM_REGS x DATA_W register file, N_RD combinational reads, one write, entry 0 reads zero,
// optional write bypass, sweep-based clear and a per-entry pending scoreboard.
module regfile_z_nr1w_param
  import regfile_pkg::*;
#(
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned N_RD     = 2,
  parameter int unsigned BYPASS   = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  regfile_z_nr1w_param_if.slave     bus
);

  localparam int unsigned AW = calc_aw(NUM_REGS);

  logic                busy;
  logic                clr_wen;
  logic [AW-1:0]       clr_addr;
  logic                user_we;
  logic                arr_we;
  logic [AW-1:0]       arr_addr;
  logic [DATA_W-1:0]   arr_wdata;
  logic [NUM_REGS-1:0] pending_q, pending_d;
  logic [DATA_W-1:0]   mem_q [NUM_REGS];

  regfile_clear_fsm #(
    .NUM_REGS (NUM_REGS),
    .AW       (AW)
  ) u_clear_fsm (
    .clk         (clk),
    .rst         (rst),
    .clear_req_i (bus.clear_req),
    .busy_o      (busy),
    .clr_wen_o   (clr_wen),
    .clr_addr_o  (clr_addr)
  );

  assign user_we = bus.wen && (bus.waddr != '0) && !busy;

  // Clear engine owns the write port for the whole sweep.
  always_comb begin
    arr_we    = clr_wen;
    arr_addr  = clr_addr;
    arr_wdata = '0;
    if (!clr_wen) begin
      arr_we    = user_we;
      arr_addr  = bus.waddr;
      arr_wdata = bus.wdata;
    end
  end

  // Allocation is applied after the writeback clear so a new producer wins.
  always_comb begin
    pending_d = pending_q;
    if (busy) begin
      pending_d = '0;
    end else begin
      if (user_we) begin
        pending_d[bus.waddr] = 1'b0;
      end
      if (bus.alloc_en && (bus.alloc_addr != '0)) begin
        pending_d[bus.alloc_addr] = 1'b1;
      end
    end
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
      if (arr_we) begin
        mem_q[arr_addr] <= arr_wdata;
      end
    end
  end

  for (genvar gi = 0; gi < N_RD; gi++) begin : g_rd
    logic [AW-1:0]     ra;
    logic [DATA_W-1:0] rd;

    assign ra = bus.raddr[gi*AW +: AW];

    // Unswept entries may hold garbage, so reads are forced to zero while busy.
    always_comb begin
      rd = mem_q[ra];
      if (busy || (ra == '0)) begin
        rd = '0;
      end else if ((BYPASS != 0) && user_we && (bus.waddr == ra)) begin
        rd = bus.wdata;
      end
    end

    assign bus.rdata[gi*DATA_W +: DATA_W] = rd;
  end

  assign bus.busy    = busy;
  assign bus.pending = busy ? '0 : pending_q;

endmodule
